// File: rtl/sar_dac_pkg.sv
// Shared types and constants for the SAR DAC controller.
// SAR_AVG_EN (build macro) enables 4x averaging in sar_dac_ctrl.
package sar_dac_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned SETTLE_DEF = 4;
  localparam int unsigned AVG_COUNT  = 4;
  localparam int unsigned AVG_SHIFT  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sar_dac_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_dac_ctrl.sv
// SAR engine driving the R2R DAC from an external comparator, with manual DAC drive when idle.
// Build macro SAR_AVG_EN: each start averages 4 back-to-back conversions.
module sar_dac_ctrl
  import sar_dac_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp_in,
  input  logic             manual_en,
  input  logic [WIDTH-1:0] manual_code,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   bit_idx, idx_nxt, idx_dn;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   code_nxt, result_nxt, decided;
  logic               busy_nxt, done_nxt;
  logic               comp_s;

`ifdef SAR_AVG_EN
  localparam int unsigned ACC_W  = WIDTH + 2;
  localparam int unsigned CONV_W = $clog2(AVG_COUNT);
  logic [ACC_W-1:0]  acc, acc_nxt, acc_sum;
  logic [CONV_W-1:0] conv, conv_nxt;
`endif

  sync_2ff u_comp_sync (
    .clk (clk),
    .rst (rst),
    .d   (comp_in),
    .q   (comp_s)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      cnt      <= '0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
`ifdef SAR_AVG_EN
      acc      <= '0;
      conv     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      bit_idx  <= idx_nxt;
      cnt      <= cnt_nxt;
      dac_code <= code_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      result   <= result_nxt;
`ifdef SAR_AVG_EN
      acc      <= acc_nxt;
      conv     <= conv_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    idx_nxt    = bit_idx;
    cnt_nxt    = cnt;
    code_nxt   = dac_code;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    idx_dn     = bit_idx - IDX_W'(1);
    decided    = dac_code;
    if (!comp_s) decided[bit_idx] = 1'b0;
`ifdef SAR_AVG_EN
    acc_nxt    = acc;
    conv_nxt   = conv;
    acc_sum    = acc + ACC_W'(decided);
`endif

    case (state)
      IDLE: begin
        if (start) begin
          code_nxt  = MSB_CODE;
          idx_nxt   = TOP_IDX;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SETTLE;
`ifdef SAR_AVG_EN
          acc_nxt   = '0;
          conv_nxt  = '0;
`endif
        end else if (manual_en) begin
          code_nxt = manual_code;
        end
      end

      SETTLE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = DECIDE;
      end

      DECIDE: begin
        code_nxt = decided;
        if (bit_idx != '0) begin
          code_nxt[idx_dn] = 1'b1;
          idx_nxt          = idx_dn;
          cnt_nxt          = '0;
          state_nxt        = SETTLE;
        end else begin
`ifdef SAR_AVG_EN
          // Chain the next conversion directly; only the last one reports.
          if (conv != CONV_W'(AVG_COUNT - 1)) begin
            acc_nxt   = acc_sum;
            conv_nxt  = conv + CONV_W'(1);
            code_nxt  = MSB_CODE;
            idx_nxt   = TOP_IDX;
            cnt_nxt   = '0;
            state_nxt = SETTLE;
          end else begin
            acc_nxt    = acc_sum;
            result_nxt = WIDTH'(acc_sum >> AVG_SHIFT);
            state_nxt  = DONE;
          end
`else
          result_nxt = decided;
          state_nxt  = DONE;
`endif
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_dac_ctrl.sv
// Self-checking bench for sar_dac_ctrl with a behavioural comparator and result scoreboard.
module tb_sar_dac_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned SC   = 4;
  localparam int          STEP = SC + 1;
`ifdef SAR_AVG_EN
  localparam int          LAT  = 4 * W * STEP + 1;
`else
  localparam int          LAT  = W * STEP + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         manual_en = 1'b0;
  logic [W-1:0] manual_code = '0;
  logic [W-1:0] vin = '0;
  logic         comp_in;
  logic [W-1:0] dac_code;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb[$];

  assign comp_in = (vin >= dac_code);

  always #5 clk = ~clk;

  sar_dac_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .comp_in     (comp_in),
    .manual_en   (manual_en),
    .manual_code (manual_code),
    .dac_code    (dac_code),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion request; observations are taken on the falling edge after rising edge 'cyc',
  // where rising edge 0 is the one that samples start.
  task automatic run_conv(input logic [W-1:0] v, input bit ramp,
                          input int re_a, input int re_b, input int re_c, input int rst_at);
    int cyc;
    int k;
    int b;
    int dones;
    int limit;
    bit fin;
    logic [W-1:0] m;
    vin   = v;
    m     = {1'b1, {(W-1){1'b0}}};
    b     = W - 1;
    k     = 0;
    dones = 0;
    fin   = 1'b0;
    limit = (rst_at >= 0) ? rst_at + LAT + 5 : LAT + 20;
    if (rst_at < 0) begin
      if (ramp) sb.push_back(W'((4 * int'(v) + 6) / 4));
      else      sb.push_back(v);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!fin) begin
      if (ramp && (cyc % (W * STEP)) == 0 && cyc < 4 * W * STEP)
        vin = v + W'(cyc / (W * STEP));
      if (cyc == 0) chk("busy_after_start", 32'(busy), 32'd1);
      if (rst_at < 0 && cyc == LAT - 1) chk("busy_before_done", 32'(busy), 32'd1);
      if (k < int'(W) && cyc == k * STEP && !(rst_at >= 0 && cyc >= rst_at)) begin
        chk($sformatf("trial_code_%0d", k), 32'(dac_code), 32'(m));
        if (v < m) m[b] = 1'b0;
        if (b > 0) m[b-1] = 1'b1;
        b--;
        k++;
      end
      if (rst_at >= 0 && cyc == rst_at) begin
        chk("rst_dac_code", 32'(dac_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b0;
      end
      if (done) begin
        dones++;
        if (rst_at < 0) begin
          chk("done_latency", 32'(cyc), 32'(LAT));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("dac_holds_result", 32'(dac_code), 32'(vin));
          if (sb.size() > 0) chk("result", 32'(result), 32'(sb.pop_front()));
          else chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
          fin = 1'b1;
        end
      end
      if (!fin && cyc >= limit) begin
        if (rst_at < 0) chk("done_timeout", 32'(dones), 32'd1);
        else            chk("no_done_after_rst", 32'(dones), 32'd0);
        fin = 1'b1;
      end
      if (!fin) begin
        start = (cyc + 1 == re_a) || (cyc + 1 == re_b) || (cyc + 1 == re_c);
        if (rst_at >= 0 && cyc + 1 == rst_at) rst = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    if (rst_at < 0) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done) dones++;
        if (i == 0) begin
          if (manual_en) chk("manual_resume", 32'(dac_code), 32'(manual_code));
          else           chk("idle_hold", 32'(dac_code), 32'(vin));
        end
      end
      chk("single_done", 32'(dones), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dac_code", 32'(dac_code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(8'hA5, 1'b0, -1, -1, -1, -1);
    run_conv(8'h00, 1'b0, -1, -1, -1, -1);
    run_conv(8'hFF, 1'b0, -1, -1, -1, -1);
    run_conv(8'h3C, 1'b0, 5, 40, LAT, -1);
    run_conv(8'h99, 1'b0, -1, -1, -1, 20);
    run_conv(8'h5A, 1'b0, -1, -1, -1, -1);

    manual_en   = 1'b1;
    manual_code = 8'h77;
    @(negedge clk);
    chk("manual_drive", 32'(dac_code), 32'h77);
    run_conv(8'h2E, 1'b0, -1, -1, -1, -1);
    chk("manual_after_conv", 32'(dac_code), 32'h77);
    manual_en = 1'b0;

`ifdef SAR_AVG_EN
    run_conv(8'h10, 1'b1, -1, -1, -1, -1);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
